// File: rtl/riscv_br_pkg.sv
// Shared branch definitions: comparator opcodes, predictor FSM states and
// the BHT counter reset value.
package riscv_br_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [1:0] CTR_RESET = 2'b01;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } br_state_e;

    // funct3 010/011 have no branch meaning; such a branch resolves not-taken
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return !(f3 inside {BEQ, BNE, BLT, BGE, BLTU, BGEU});
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_counters.sv
// Array of 2-bit saturating counters: async read for ID, one train port for EX
// and one init-write port. Init has priority over training.
module bht_counters
    import riscv_br_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic [IDXW-1:0] rd_idx,
    output logic [1:0]      rd_ctr,
    input  logic            train_en,
    input  logic [IDXW-1:0] train_idx,
    input  logic            train_up,
    input  logic            init_en,
    input  logic [IDXW-1:0] init_idx
);

    logic [1:0] ctr [ENTRIES];

    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk) begin
        if (init_en) begin
            ctr[init_idx] <= CTR_RESET;
        end else if (train_en) begin
            if (train_up && ctr[train_idx] != 2'b11) begin
                ctr[train_idx] <= ctr[train_idx] + 2'b01;
            end else if (!train_up && ctr[train_idx] != 2'b00) begin
                ctr[train_idx] <= ctr[train_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction/resolution controller: BHT lookup in ID, resolution,
// redirect and flush generation in EX, BHT training and statistics.
//
// state   | meaning
// ST_INIT | writing CTR_RESET into one BHT entry per cycle; no prediction/training
// ST_RUN  | BHT valid; predict in ID, train on each resolved branch
module branch_predict_ctrl
    import riscv_br_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_is_branch,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    output logic [2:0]      br_funct3,
    input  logic            br_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            illegal_br,
    output logic            ready,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDXW = $clog2(BHT_ENTRIES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BHT_ENTRIES - 1);

    br_state_e       state;
    logic [IDXW-1:0] init_idx;
    logic [IDXW-1:0] id_idx;
    logic [IDXW-1:0] ex_idx;
    logic [1:0]      id_ctr;
    logic            f3_bad;
    logic            act;
    logic            res;
    logic            mispredict;
    logic            id_redirect;

    assign id_idx  = id_pc[IDXW+1:2];
    assign ex_idx  = ex_pc[IDXW+1:2];
    assign ready   = (state == ST_RUN);

    assign br_funct3  = ex_funct3;
    assign f3_bad     = is_illegal_f3(ex_funct3);
    assign act        = br_taken & ~f3_bad;
    assign illegal_br = ex_valid & ex_is_branch & f3_bad;
    assign res        = ex_valid & ex_is_branch & ~ex_stall;
    assign mispredict = res & (act != ex_pred_taken);

    assign pred_taken  = id_valid & id_is_branch & id_ctr[1] & ready;
    assign id_redirect = pred_taken & ~ex_stall & ~mispredict;

    bht_counters #(
        .ENTRIES (BHT_ENTRIES),
        .IDXW    (IDXW)
    ) u_bht (
        .clk       (clk),
        .rd_idx    (id_idx),
        .rd_ctr    (id_ctr),
        .train_en  (res & ready & ~rst),
        .train_idx (ex_idx),
        .train_up  (act),
        .init_en   ((state == ST_INIT) & ~rst),
        .init_idx  (init_idx)
    );

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (mispredict) begin
            redirect    = 1'b1;
            redirect_pc = act ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (id_redirect) begin
            redirect    = 1'b1;
            redirect_pc = id_pc + id_imm;
            flush_if_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with BHT_ENTRIES=16, XLEN=32.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_is_branch;
    logic [31:0] id_pc, id_imm;
    logic        pred_taken;
    logic        ex_valid, ex_stall, ex_is_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm;
    logic        ex_pred_taken;
    logic [2:0]  br_funct3;
    logic        br_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex, illegal_br, ready;
    logic [31:0] stat_branches, stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.BHT_ENTRIES(16), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_pc            (id_pc),
        .id_imm           (id_imm),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_is_branch     (ex_is_branch),
        .ex_funct3        (ex_funct3),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_pred_taken    (ex_pred_taken),
        .br_funct3        (br_funct3),
        .br_taken         (br_taken),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .illegal_br       (illegal_br),
        .ready            (ready),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_is_branch = 0; id_pc = 0; id_imm = 0;
    endtask

    task automatic idle_ex();
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_funct3 = 3'b000;
        ex_pc = 0; ex_imm = 0; ex_pred_taken = 0; br_taken = 0;
    endtask

    task automatic set_ex(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic tk);
        ex_valid = 1; ex_is_branch = 1; ex_stall = 0; ex_funct3 = f3;
        ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; br_taken = tk;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] imm);
        id_valid = 1; id_is_branch = 1; id_pc = pc; id_imm = imm;
    endtask

    initial begin
        rst = 1;
        idle_id();
        idle_ex();
        set_id(32'h40, 32'h10);
        tick();
        tick();
        // reset state
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_pred", pred_taken, 1'b0);
        chk32("rst_stat_br", stat_branches, 32'd0);
        chk32("rst_stat_mp", stat_mispredicts, 32'd0);
        chk1("rst_redirect", redirect, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);

        rst = 0;
        idle_id();
        for (int i = 0; i < 15; i++) tick();
        chk1("init_ready_15", ready, 1'b0);
        tick();
        chk1("init_ready_16", ready, 1'b1);

        set_id(32'h40, 32'h10);
        #1;
        chk1("weak_nt_pred", pred_taken, 1'b0);
        chk1("weak_nt_redirect", redirect, 1'b0);
        idle_id();

        // beq taken, predicted not-taken, twice: BHT[0] 01 -> 10 -> 11
        set_ex(3'b000, 32'h100, 32'h20, 1'b0, 1'b1);
        #1;
        chk1("beq_redirect", redirect, 1'b1);
        chk32("beq_redirect_pc", redirect_pc, 32'h120);
        chk1("beq_flush_if_id", flush_if_id, 1'b1);
        chk1("beq_flush_id_ex", flush_id_ex, 1'b1);
        chk32("beq_funct3", {29'd0, br_funct3}, 32'd0);
        tick();
        chk32("beq1_stat_mp", stat_mispredicts, 32'd1);
        chk32("beq1_stat_br", stat_branches, 32'd1);
        tick();
        chk32("beq2_stat_mp", stat_mispredicts, 32'd2);
        idle_ex();

        set_id(32'h100, 32'h20);
        #1;
        chk1("id_pred_taken", pred_taken, 1'b1);
        chk1("id_redirect", redirect, 1'b1);
        chk32("id_redirect_pc", redirect_pc, 32'h120);
        chk1("id_flush_if_id", flush_if_id, 1'b1);
        chk1("id_flush_id_ex", flush_id_ex, 1'b0);

        // bge predicted taken, not taken, overrides the ID redirect
        set_ex(3'b101, 32'h200, 32'h40, 1'b1, 1'b0);
        #1;
        chk1("bge_redirect", redirect, 1'b1);
        chk32("bge_redirect_pc", redirect_pc, 32'h204);
        chk1("bge_flush_if_id", flush_if_id, 1'b1);
        chk1("bge_flush_id_ex", flush_id_ex, 1'b1);
        tick();
        chk32("bge_stat_br", stat_branches, 32'd3);
        chk32("bge_stat_mp", stat_mispredicts, 32'd3);
        idle_id();

        // four not-taken at index 1 (01 -> 00 -> 00 ...), correctly predicted
        set_ex(3'b001, 32'h104, 32'h8, 1'b0, 1'b0);
        #1;
        chk1("nt_ok_redirect", redirect, 1'b0);
        chk32("nt_ok_redirect_pc", redirect_pc, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk32("nt4_stat_br", stat_branches, 32'd7);
        chk32("nt4_stat_mp", stat_mispredicts, 32'd3);
        // one taken: 00 -> 01 (a wrapped counter would predict taken here)
        set_ex(3'b001, 32'h104, 32'h8, 1'b0, 1'b1);
        tick();
        idle_ex();
        set_id(32'h104, 32'h8);
        #1;
        chk1("sat0_pred", pred_taken, 1'b0);
        set_ex(3'b001, 32'h104, 32'h8, 1'b0, 1'b1);
        idle_id();
        tick();
        idle_ex();
        set_id(32'h104, 32'h8);
        #1;
        chk1("ctr2_pred", pred_taken, 1'b1);
        chk32("ctr2_redirect_pc", redirect_pc, 32'h10c);
        chk32("ctr2_stat_mp", stat_mispredicts, 32'd5);
        idle_id();

        // illegal funct3 with br_taken=1 resolves not-taken
        set_ex(3'b010, 32'h300, 32'h10, 1'b0, 1'b1);
        #1;
        chk1("ill_flag", illegal_br, 1'b1);
        chk1("ill_nopred_redirect", redirect, 1'b0);
        chk32("ill_funct3", {29'd0, br_funct3}, 32'd2);
        tick();
        set_ex(3'b011, 32'h300, 32'h10, 1'b1, 1'b1);
        #1;
        chk1("ill_pred_redirect", redirect, 1'b1);
        chk32("ill_pred_redirect_pc", redirect_pc, 32'h304);
        tick();
        chk32("ill_stat_br", stat_branches, 32'd11);
        chk32("ill_stat_mp", stat_mispredicts, 32'd6);
        set_ex(3'b000, 32'h300, 32'h10, 1'b0, 1'b1);
        #1;
        chk1("legal_flag", illegal_br, 1'b0);

        // correct taken prediction at index 1
        set_ex(3'b000, 32'h104, 32'h8, 1'b1, 1'b1);
        #1;
        chk1("tk_ok_redirect", redirect, 1'b0);
        tick();
        chk32("tk_ok_stat_br", stat_branches, 32'd12);
        chk32("tk_ok_stat_mp", stat_mispredicts, 32'd6);

        // stall: mispredicting branch in EX and predicted-taken branch in ID
        set_ex(3'b000, 32'h100, 32'h20, 1'b0, 1'b1);
        ex_stall = 1;
        set_id(32'h104, 32'h8);
        for (int i = 0; i < 3; i++) begin
            br_taken = i[0] ? 1'b0 : 1'b1;
            #1;
            chk1("stall_redirect", redirect, 1'b0);
            chk1("stall_flush", flush_if_id, 1'b0);
            tick();
        end
        chk32("stall_stat_br", stat_branches, 32'd12);
        chk32("stall_stat_mp", stat_mispredicts, 32'd6);
        ex_stall = 0;
        idle_ex();
        #1;
        chk1("post_stall_pred", pred_taken, 1'b1);

        // reset pulse in RUN
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk1("rerst_ready", ready, 1'b0);
        chk1("rerst_pred", pred_taken, 1'b0);
        chk32("rerst_stat_br", stat_branches, 32'd0);
        chk32("rerst_stat_mp", stat_mispredicts, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and resolution controller for the 5-stage RISC-V pipeline. It predicts conditional branches in ID from a table of 2-bit saturating counters (BHT) and drives the branch comparator's opcode in EX. It resolves each branch against the comparator's outcome and generates the PC redirect and pipeline flushes. It also trains the BHT and keeps branch/mispredict statistics.

## Interface
- BHT_ENTRIES, 16, number of BHT counters; power of two, 4..256; IDXW = log2(BHT_ENTRIES)
- XLEN, 32, address/immediate width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_is_branch  in  1  ID instruction is a conditional branch
- id_pc  in  XLEN  PC of the ID instruction
- id_imm  in  XLEN  sign-extended B-type immediate in ID
- pred_taken  out  1  prediction for the ID branch; pipeline carries it to EX
- ex_valid  in  1  EX stage holds a valid instruction
- ex_stall  in  1  EX is frozen this cycle; nothing resolves
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_funct3  in  3  branch funct3 of the EX instruction
- ex_pc  in  XLEN  PC of the EX instruction
- ex_imm  in  XLEN  B-type immediate in EX
- ex_pred_taken  in  1  prediction made for this branch in ID
- br_funct3  out  3  opcode to the comparator: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
- br_taken  in  1  comparator outcome, same cycle
- redirect  out  1  load redirect_pc into the PC this cycle
- redirect_pc  out  XLEN  next fetch address
- flush_if_id  out  1  squash the IF/ID register
- flush_id_ex  out  1  squash the ID/EX register
- illegal_br  out  1  EX branch has funct3 010 or 011
- ready  out  1  BHT initialisation complete
- stat_branches  out  32  count of resolved branches
- stat_mispredicts  out  32  count of mispredicted branches

## Operation
- FSM has two states, INIT and RUN. Reset enters INIT with init index 0.
- INIT writes counter value 01 (weakly not-taken) into one entry per cycle, at the current init index. After entry BHT_ENTRIES-1 it goes to RUN. ready = 1 only in RUN.
- In INIT: pred_taken = 0 and BHT training is suppressed. Resolution, redirect and stats still operate normally.
- BHT index = pc[IDXW+1:2].
- pred_taken = id_valid & id_is_branch & BHT[id_idx][1] & ready.
- Branch resolves when res = ex_valid & ex_is_branch & ~ex_stall. br_funct3 = ex_funct3 at all times.
- Actual outcome: act = br_taken, except act = 0 when funct3 is 010 or 011. In that case illegal_br = ex_valid & ex_is_branch.
- mispredict = res & (act != ex_pred_taken).
- EX redirect on mispredict:
  - redirect_pc = act ? ex_pc+ex_imm : ex_pc+4 (XLEN modulo, wrap ignored).
  - flush_if_id = flush_id_ex = 1.
- ID redirect when pred_taken & ~ex_stall and no EX mispredict:
  - redirect_pc = id_pc+id_imm.
  - flush_if_id = 1, flush_id_ex = 0.
- EX mispredict always has priority over ID redirect.
- Otherwise redirect, both flushes = 0 and redirect_pc = 0.
- Training (RUN, res): BHT[ex_idx] increments if act, decrements if not, saturating at 3 and 0.
- Same-cycle ID read and EX write to one index: ID sees the old value; no bypass.
- Stats: stat_branches += 1 on every res; stat_mispredicts += 1 on every mispredict. Both are 32-bit and wrap.

## Timing
- All control outputs are combinational from current inputs and state: zero-cycle latency from br_taken to redirect.
- BHT, FSM and stats update at the clock edge ending the cycle.
- Reset values:
  - FSM = INIT, ready = 0, stats = 0, pred_taken = 0.
  - Comb outputs follow their equations with ready = 0.
  - BHT contents undefined until INIT completes (BHT_ENTRIES cycles).
- rst asserted mid-RUN or mid-INIT: next cycle is INIT index 0, stats cleared, any partial training discarded.
- ex_stall held: no training, no stats, no redirect, for any number of cycles.

## Structure
- Shared package riscv_br_pkg holds:
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU;
  - the FSM state enum;
  - the counter reset value 2'b01.
- The comparator stays a separate block; this block drives its opcode and consumes its result.
- One natural sub-module, bht_counters: counter array with one async-read port (ID), one train port (EX) and one init-write port.

## Test plan
- Reset then 16 idle cycles (BHT_ENTRIES=16) -> ready rises on cycle 16; a branch in ID at pc 0x40 gives pred_taken=0.
- beq at pc 0x100, imm 0x20, ex_pred_taken=0, br_taken=1 -> redirect=1, redirect_pc=0x120, both flushes=1, stat_mispredicts=1. A second identical beq -> BHT[0] = 3; next ID branch at 0x100 gives pred_taken=1, redirect_pc=0x120, flush_id_ex=0.
- Taken prediction, bge not taken at pc 0x200 -> redirect_pc=0x204, both flushes=1. A simultaneous ID predicted-taken branch is overridden.
- Four not-taken resolutions on a counter at 0 -> counter stays 0; stat_branches=4, stat_mispredicts=0.
- ex_funct3=010 with br_taken=1 -> illegal_br=1, act=0; mispredict only if ex_pred_taken=1.
- ex_stall=1 for 3 cycles with a resolving branch and br_taken toggling -> no redirect, stats unchanged. rst pulsed in RUN -> ready=0 and stats=0 next cycle.
